seq1001_framer_tx: RTL and testbench

- Serial frame transmitter; the sending end of the 1001-delimited overlapping serial link.
- The Mealy 1001 detector on the receiving end treats 1001 as the frame-start marker.
- Accepts a parallel word over a valid/ready handshake and emits an idle-low bit stream: 1001 header, MSB-first payload, then a zero guard gap.
- Inserts stuff bits so that 1001 never appears on the line except as a header, so the receiver's overlapping detector cannot false-trigger.

---
 rtl/seq1001_framer_tx.sv | 200 ++++++++++++++++++++
 tb/tb_seq1001_framer_tx.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq1001_framer_tx.sv
// seq1001_framer_tx: serial frame transmitter for the 1001-delimited link.
// Each accepted word goes out as an idle-low bit stream made of a 1001
// header, the payload MSB first, and then a zero guard gap. Stuff bits keep
// 1001 from appearing anywhere except in a header.
// Optional feature macro: SEQ1001_TX_PARITY_EN. When it is defined, one
// even-parity bit follows the payload. The parity bit is stuffed like the
// payload bits, and frame_done moves onto it.
module seq1001_framer_tx #(
    parameter int DATA_W    = 8,
    parameter int GUARD_LEN = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              serial_out,
    output logic              busy,
    output logic              frame_done,
    output logic              stuff_flag
);

    localparam int BC_W = $clog2(DATA_W + 1);
    localparam int GC_W = $clog2(GUARD_LEN + 1);

    localparam logic [BC_W-1:0] BIT_CNT_INIT   = BC_W'(DATA_W);
    localparam logic [GC_W-1:0] GUARD_CNT_INIT = GC_W'(GUARD_LEN);

    // Main FSM encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_HDR   = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_GUARD = 3'd3;
`ifdef SEQ1001_TX_PARITY_EN
    localparam logic [2:0] ST_PAR   = 3'd4;
`endif

    // The tracker is a 1001 detector that runs over the emitted line.
    // T3 means the line currently ends in "100".
    localparam logic [1:0] T0 = 2'b00;
    localparam logic [1:0] T1 = 2'b01;
    localparam logic [1:0] T2 = 2'b10;
    localparam logic [1:0] T3 = 2'b11;

    logic [2:0]        state_q,     state_d;
    logic [1:0]        trk_q,       trk_d;
    logic [1:0]        hdr_cnt_q,   hdr_cnt_d;
    logic [BC_W-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [GC_W-1:0]   guard_cnt_q, guard_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic              bit_d;
    logic              stuff_d;
    logic              done_d;
`ifdef SEQ1001_TX_PARITY_EN
    logic              parity_q,    parity_d;
`endif

    // Next tracker state after a bit has been emitted.
    function automatic logic [1:0] trk_next(input logic [1:0] t, input logic b);
        case (t)
            T0:      return b ? T1 : T0;
            T1:      return b ? T1 : T2;
            T2:      return b ? T1 : T3;
            default: return b ? T1 : T0;
        endcase
    endfunction

    // Ready/busy depend only on the state register, never on tx_valid
    assign tx_ready = (state_q == ST_IDLE);
    assign busy     = ~tx_ready;

    // Decide the bit for the next cycle and how the frame state advances
    always_comb begin
        // NOTE: every signal gets a default before the case so that no path leaves one unassigned (no latches).
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        guard_cnt_d = guard_cnt_q;
        shreg_d     = shreg_q;
        bit_d       = 1'b0;
        stuff_d     = 1'b0;
        done_d      = 1'b0;
`ifdef SEQ1001_TX_PARITY_EN
        parity_d    = parity_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (tx_valid) begin
                    // The first header bit goes out at the accepting edge
                    bit_d     = 1'b1;
                    state_d   = ST_HDR;
                    hdr_cnt_d = 2'd3;
                    shreg_d   = tx_data;
                    bit_cnt_d = BIT_CNT_INIT;
`ifdef SEQ1001_TX_PARITY_EN
                    parity_d  = ^tx_data;
`endif
                end
            end

            ST_HDR: begin
                // The remaining header bits are 0, 0, 1
                bit_d     = (hdr_cnt_q == 2'd1);
                hdr_cnt_d = hdr_cnt_q - 2'd1;
                if (hdr_cnt_q == 2'd1) begin
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (trk_q == T3) begin
                    // The line ends in "100". A 0 here breaks any 1001.
                    bit_d   = 1'b0;
                    stuff_d = 1'b1;
                end else begin
                    bit_d     = shreg_q[DATA_W-1];
                    shreg_d   = shreg_q << 1;
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                    if (bit_cnt_q == BC_W'(1)) begin
`ifdef SEQ1001_TX_PARITY_EN
                        state_d     = ST_PAR;
`else
                        state_d     = ST_GUARD;
                        guard_cnt_d = GUARD_CNT_INIT;
                        done_d      = 1'b1;
`endif
                    end
                end
            end

`ifdef SEQ1001_TX_PARITY_EN
            ST_PAR: begin
                if (trk_q == T3) begin
                    bit_d   = 1'b0;
                    stuff_d = 1'b1;
                end else begin
                    bit_d       = parity_q;
                    done_d      = 1'b1;
                    state_d     = ST_GUARD;
                    guard_cnt_d = GUARD_CNT_INIT;
                end
            end
`endif

            ST_GUARD: begin
                // Trailing zeros keep a "100" tail plus the next header from forming 1001
                bit_d       = 1'b0;
                guard_cnt_d = guard_cnt_q - GC_W'(1);
                if (guard_cnt_q == GC_W'(1)) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // After the header the line ends in 1, so the tracker restarts at T1
        if (state_q == ST_HDR && hdr_cnt_q == 2'd1) begin
            trk_d = T1;
        end else begin
            trk_d = trk_next(trk_q, bit_d);
        end
    end

    // Register the state, the counters and the registered line outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            trk_q       <= T0;
            hdr_cnt_q   <= 2'd0;
            bit_cnt_q   <= '0;
            guard_cnt_q <= '0;
            shreg_q     <= '0;
            serial_out  <= 1'b0;
            frame_done  <= 1'b0;
            stuff_flag  <= 1'b0;
`ifdef SEQ1001_TX_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            // NOTE: state is updated only with non-blocking assignments, so every register samples pre-edge values.
            state_q     <= state_d;
            trk_q       <= trk_d;
            hdr_cnt_q   <= hdr_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            guard_cnt_q <= guard_cnt_d;
            shreg_q     <= shreg_d;
            serial_out  <= bit_d;
            frame_done  <= done_d;
            stuff_flag  <= stuff_d;
`ifdef SEQ1001_TX_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_seq1001_framer_tx.sv
// tb_seq1001_framer_tx: self-checking bench for seq1001_framer_tx.
// The reference model builds each expected frame from the line rules
// (header, MSB-first payload, a stuffed 0 after any "100" tail). A separate
// line decoder finds headers and unstuffs the recorded serial stream.
// Compile with SEQ1001_TX_PARITY_EN to cover the parity build.
module tb_seq1001_framer_tx;

    localparam int DATA_W    = 8;
    localparam int GUARD_LEN = 3;
`ifdef SEQ1001_TX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic              clk;
    logic              rst;
    logic              tx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              serial_out;
    logic              busy;
    logic              frame_done;
    logic              stuff_flag;

    seq1001_framer_tx #(.DATA_W(DATA_W), .GUARD_LEN(GUARD_LEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_valid   (tx_valid),
        .tx_data    (tx_data),
        .tx_ready   (tx_ready),
        .serial_out (serial_out),
        .busy       (busy),
        .frame_done (frame_done),
        .stuff_flag (stuff_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Expected frame built by the model
    bit exp_bit[$];
    bit exp_stf[$];
    bit exp_done[$];

    // Observations from the most recent frame
    int obs_len;
    int obs_stuffs;
    int obs_first_stuff;

    // Recorded line and decoder results
    bit                line_q[$];
    bit                rec_en = 1'b0;
    logic [DATA_W-1:0] dec_q[$];
    int                dec_starts;
    logic [DATA_W-1:0] sent_q[$];

    always @(negedge clk) begin
        if (rec_en) line_q.push_back(serial_out);
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        assert (act === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void push_bit(input bit b, input bit s);
        exp_bit.push_back(b);
        exp_stf.push_back(s);
        exp_done.push_back(1'b0);
    endfunction

    function automatic bit ends_100();
        int n = exp_bit.size();
        return (n >= 3) && exp_bit[n-3] && !exp_bit[n-2] && !exp_bit[n-1];
    endfunction

    function automatic void push_payload(input bit b);
        if (ends_100()) push_bit(1'b0, 1'b1);
        push_bit(b, 1'b0);
    endfunction

    function automatic void build_expected(input logic [DATA_W-1:0] w);
        exp_bit.delete();
        exp_stf.delete();
        exp_done.delete();
        push_bit(1'b1, 1'b0);
        push_bit(1'b0, 1'b0);
        push_bit(1'b0, 1'b0);
        push_bit(1'b1, 1'b0);
        for (int i = DATA_W - 1; i >= 0; i--) push_payload(w[i]);
`ifdef SEQ1001_TX_PARITY_EN
        push_payload(^w);
`endif
        exp_done[exp_done.size()-1] = 1'b1;
    endfunction

    // ---------------- line analysis ----------------
    function automatic int count_1001();
        int n = 0;
        for (int i = 3; i < line_q.size(); i++) begin
            if (line_q[i-3] && !line_q[i-2] && !line_q[i-1] && line_q[i]) n++;
        end
        return n;
    endfunction

    function automatic void decode_line();
        int i, j, cnt;
        logic [DATA_W-1:0] w;
        dec_q.delete();
        dec_starts = 0;
        i = 3;
        while (i < line_q.size()) begin
            if (line_q[i-3] && !line_q[i-2] && !line_q[i-1] && line_q[i]) begin
                dec_starts++;
                j   = i + 1;
                cnt = 0;
                w   = '0;
                while (cnt < DATA_W + PAR_BITS && j < line_q.size()) begin
                    if (line_q[j-3] && !line_q[j-2] && !line_q[j-1]) begin
                        j++;
                    end else begin
                        if (cnt < DATA_W) w = (w << 1) | DATA_W'(line_q[j]);
                        cnt++;
                        j++;
                    end
                end
                if (cnt == DATA_W + PAR_BITS) dec_q.push_back(w);
                i = j + 3;
            end else begin
                i++;
            end
        end
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at the negedge right after acceptance; returns at the negedge of the last frame bit
    task automatic expect_frame(input logic [DATA_W-1:0] w);
        build_expected(w);
        obs_len         = 0;
        obs_stuffs      = 0;
        obs_first_stuff = -1;
        for (int i = 0; i < exp_bit.size(); i++) begin
            if (i > 0) @(negedge clk);
            check($sformatf("w%02h_bit%0d", w, i), 32'(serial_out), 32'(exp_bit[i]));
            check($sformatf("w%02h_stuff%0d", w, i), 32'(stuff_flag), 32'(exp_stf[i]));
            check($sformatf("w%02h_done%0d", w, i), 32'(frame_done), 32'(exp_done[i]));
            check($sformatf("w%02h_rdybusy%0d", w, i), 32'({tx_ready, busy}), 32'(2'b01));
            if (stuff_flag) begin
                obs_stuffs++;
                if (obs_first_stuff < 0) obs_first_stuff = i;
            end
            if (frame_done && obs_len == 0) obs_len = i + 1;
        end
    endtask

    task automatic expect_guard();
        int ready_at = 0;
        for (int g = 1; g <= GUARD_LEN; g++) begin
            @(negedge clk);
            check($sformatf("guard_line%0d", g), 32'(serial_out), 32'd0);
            check($sformatf("guard_done%0d", g), 32'(frame_done), 32'd0);
            if (tx_ready && ready_at == 0) ready_at = g;
        end
        check("guard_ready_gap", 32'(ready_at), 32'(GUARD_LEN));
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input bit keep_valid);
        int n = 0;
        while (!tx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_send", 32'(tx_ready), 32'd1);
        if (!tx_ready) return;
        tx_valid = 1'b1;
        tx_data  = w;
        @(negedge clk);
        if (!keep_valid) tx_valid = 1'b0;
        tx_data = DATA_W'($urandom);
        expect_frame(w);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = '0;

        // Reset state
        #1;
        check("rst_line", 32'(serial_out), 32'd0);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_stuff", 32'(stuff_flag), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // F0: 1001 1111 00 [s] 00, stuff on payload cycle 7
        send_word(8'hF0, 1'b0);
        check("f0_len", 32'(obs_len), 32'(13 + PAR_BITS));
        check("f0_stuffs", 32'(obs_stuffs), 32'd1);
        check("f0_stuff_pos", 32'(obs_first_stuff), 32'd10);
        expect_guard();

        // 00: exactly one stuff, right after the second payload zero
        send_word(8'h00, 1'b0);
        check("z_len", 32'(obs_len), 32'(13 + PAR_BITS));
        check("z_stuffs", 32'(obs_stuffs), 32'd1);
        check("z_stuff_pos", 32'(obs_first_stuff), 32'd6);
        expect_guard();

        // 99: two stuffs, and 1001 on the line only as the header
        line_q.delete();
        rec_en = 1'b1;
        send_word(8'h99, 1'b0);
        check("n99_len", 32'(obs_len), 32'(14 + PAR_BITS));
        check("n99_stuffs", 32'(obs_stuffs), 32'd2);
        expect_guard();
        check("n99_detects", 32'(count_1001()), 32'd1);

        // Back-to-back with tx_valid held high
        line_q.delete();
        send_word(8'hA5, 1'b1);
        expect_guard();
        check("b2b_valid_held", 32'(tx_valid), 32'd1);
        send_word(8'h3C, 1'b0);
        expect_guard();
        decode_line();
        check("b2b_starts", 32'(dec_starts), 32'd2);
        check("b2b_words", 32'(dec_q.size()), 32'd2);
        if (dec_q.size() == 2) begin
            check("b2b_word0", 32'(dec_q[0]), 32'h0A5);
            check("b2b_word1", 32'(dec_q[1]), 32'h03C);
        end

        // Reset in the middle of a frame, during the third payload bit of FF
        check("ab_ready", 32'(tx_ready), 32'd1);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (6) @(negedge clk);
        check("ab_pre_line", 32'(serial_out), 32'd1);
        check("ab_pre_busy", 32'(busy), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("ab_line", 32'(serial_out), 32'd0);
        check("ab_ready_now", 32'(tx_ready), 32'd1);
        check("ab_busy_now", 32'(busy), 32'd0);
        check("ab_done", 32'(frame_done), 32'd0);
        check("ab_stuff", 32'(stuff_flag), 32'd0);
        @(posedge clk);
        #1;
        check("ab_hold_line", 32'(serial_out), 32'd0);
        check("ab_hold_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        send_word(8'h5A, 1'b0);
        check("ab_next_len", 32'(obs_len), 32'(exp_bit.size()));
        expect_guard();

`ifdef SEQ1001_TX_PARITY_EN
        // Parity build: 07 ends with a parity 1 that carries frame_done
        send_word(8'h07, 1'b0);
        check("p07_len", 32'(obs_len), 32'd14);
        check("p07_last_bit", 32'(serial_out), 32'd1);
        expect_guard();
`endif

        // Randomized words with random idle gaps, decoded from the line
        line_q.delete();
        sent_q.delete();
        for (int k = 0; k < 16; k++) begin
            logic [DATA_W-1:0] w;
            w = DATA_W'($urandom);
            sent_q.push_back(w);
            send_word(w, 1'b0);
            expect_guard();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        repeat (2) @(negedge clk);
        rec_en = 1'b0;
        decode_line();
        check("rnd_starts", 32'(dec_starts), 32'(sent_q.size()));
        check("rnd_detects", 32'(count_1001()), 32'(sent_q.size()));
        check("rnd_words", 32'(dec_q.size()), 32'(sent_q.size()));
        for (int k = 0; k < sent_q.size() && k < dec_q.size(); k++) begin
            check($sformatf("rnd_word%0d", k), 32'(dec_q[k]), 32'(sent_q[k]));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
